fetch_npc: RTL and testbench

FETCH_NPC -- requirements
Module: fetch_npc

---
 rtl/fetch_npc_if.sv | 38 +++
 rtl/fetch_npc.sv | 170 +++++++++++++++++
 tb/tb_fetch_npc.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_npc_if.sv
// Fetch-stage bundle: instruction-memory handshake, redirect and return-stack
// hookups, and the fetched-word hand-off to decode.
interface fetch_npc_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [31:0]         imem_rdata;
  logic                ex_redirect;
  logic [PC_WIDTH-1:0] ex_target;
  logic [PC_WIDTH-1:0] pcplus4;
  logic                i_jal;
  logic                i_jr;
  logic [PC_WIDTH-1:0] ret_addr;
  logic                if_valid;
  logic [31:0]         if_instr;
  logic [PC_WIDTH-1:0] if_pc;
  logic                if_pred;
  logic                id_ready;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, pcplus4, i_jal, i_jr,
           if_valid, if_instr, if_pc, if_pred,
    input  imem_gnt, imem_rvalid, imem_rdata, ex_redirect, ex_target,
           ret_addr, id_ready
  );

  // Memory / execute / return-stack / decode side
  modport slave (
    input  imem_req, imem_addr, pcplus4, i_jal, i_jr,
           if_valid, if_instr, if_pc, if_pred,
    output imem_gnt, imem_rvalid, imem_rdata, ex_redirect, ex_target,
           ret_addr, id_ready
  );
endinterface

// File: rtl/fetch_npc.sv
// Fetch next-PC unit: issues one instruction fetch at a time, predecodes
// JAL / RET on the returned word to steer the next PC, drives return-stack
// push/pop strobes, and buffers one word in a skid register when decode stalls.
module fetch_npc #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h0000_0000)
) (
  input logic       clk,
  input logic       rst_b,
  fetch_npc_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetchState_t;

  fetchState_t         r_state;
  fetchState_t         w_nextState;
  logic                r_drop;
  logic                w_nextDrop;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_ifValid;
  logic [31:0]         r_ifInstr;
  logic [PC_WIDTH-1:0] r_ifPc;
  logic                r_ifPred;
  logic [31:0]         r_skidInstr;
  logic [PC_WIDTH-1:0] r_skidPc;
  logic                r_skidPred;

  logic                w_accept;
  logic                w_isJal;
  logic                w_isRet;
  logic                w_canLoad;
  logic [PC_WIDTH-1:0] w_pcPlus4;
  logic [PC_WIDTH-1:0] w_jalTarget;
  logic [PC_WIDTH-1:0] w_nextPc;

  // Predecode of the response word and next-PC selection
  always_comb begin
    w_pcPlus4   = r_pc + PC_WIDTH'(4);
    w_isJal     = (bus.imem_rdata[31:26] == 6'b000011);
    w_isRet     = (bus.imem_rdata[31:26] == 6'b000000) &&
                  (bus.imem_rdata[5:0]   == 6'b001000) &&
                  (bus.imem_rdata[25:21] == 5'd31);
    w_jalTarget = {w_pcPlus4[PC_WIDTH-1:28], bus.imem_rdata[25:0], 2'b00};
    w_accept    = (r_state == WAIT) && bus.imem_rvalid && !r_drop &&
                  !bus.ex_redirect;
    w_canLoad   = !r_ifValid || bus.id_ready;
    if (w_isJal) begin
      w_nextPc = w_jalTarget;
    end else if (w_isRet) begin
      w_nextPc = bus.ret_addr;
    end else begin
      w_nextPc = w_pcPlus4;
    end
  end

  // State and drop-flag register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_drop  <= w_nextDrop;
    end
  end

  // Next-state logic; a redirect always wins and decides whether the
  // in-flight response must be thrown away
  always_comb begin
    w_nextState = r_state;
    w_nextDrop  = r_drop;
    case (r_state)
      IDLE: begin
        w_nextState = REQ;
      end
      REQ: begin
        if (bus.ex_redirect && bus.imem_gnt) begin
          w_nextState = WAIT;
          w_nextDrop  = 1'b1;
        end else if (bus.ex_redirect) begin
          w_nextState = REQ;
        end else if (bus.imem_gnt) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (bus.ex_redirect) begin
          if (bus.imem_rvalid) begin
            w_nextState = REQ;
            w_nextDrop  = 1'b0;
          end else begin
            w_nextState = WAIT;
            w_nextDrop  = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (r_drop) begin
            w_nextState = REQ;
            w_nextDrop  = 1'b0;
          end else if (w_canLoad) begin
            w_nextState = REQ;
          end else begin
            w_nextState = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.ex_redirect || bus.id_ready) begin
          w_nextState = REQ;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextDrop  = 1'b0;
      end
    endcase
  end

  // Output logic: request strobe, fetch address and return-stack strobes
  always_comb begin
    bus.imem_req  = (r_state == REQ);
    bus.imem_addr = r_pc;
    bus.pcplus4   = w_pcPlus4;
    bus.i_jal     = w_accept && w_isJal;
    bus.i_jr      = w_accept && w_isRet && !w_isJal;
  end

  // PC, decode-facing word and skid buffer
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pc        <= RESET_PC;
      r_ifValid   <= 1'b0;
      r_ifInstr   <= '0;
      r_ifPc      <= '0;
      r_ifPred    <= 1'b0;
      r_skidInstr <= '0;
      r_skidPc    <= '0;
      r_skidPred  <= 1'b0;
    end else if (bus.ex_redirect) begin
      r_pc        <= bus.ex_target;
      r_ifValid   <= 1'b0;
      r_skidInstr <= '0;
      r_skidPc    <= '0;
      r_skidPred  <= 1'b0;
    end else if (w_accept && w_canLoad) begin
      r_pc      <= w_nextPc;
      r_ifValid <= 1'b1;
      r_ifInstr <= bus.imem_rdata;
      r_ifPc    <= r_pc;
      r_ifPred  <= w_isJal || w_isRet;
    end else if (w_accept) begin
      r_pc        <= w_nextPc;
      r_skidInstr <= bus.imem_rdata;
      r_skidPc    <= r_pc;
      r_skidPred  <= w_isJal || w_isRet;
    end else if ((r_state == HOLD) && bus.id_ready) begin
      r_ifValid <= 1'b1;
      r_ifInstr <= r_skidInstr;
      r_ifPc    <= r_skidPc;
      r_ifPred  <= r_skidPred;
    end else if (bus.id_ready) begin
      r_ifValid <= 1'b0;
    end
  end

  assign bus.if_valid = r_ifValid;
  assign bus.if_instr = r_ifInstr;
  assign bus.if_pc    = r_ifPc;
  assign bus.if_pred  = r_ifPred;

endmodule

// File: tb/tb_fetch_npc.sv
// Self-checking bench for fetch_npc: directed fetch sequences with a
// scoreboard of words expected at the decode hand-off.
module tb_fetch_npc;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } sbEntry_t;

  logic clk;
  logic rst_b;
  int   checkCount;
  int   failCount;
  sbEntry_t sbQueue[$];

  fetch_npc_if #(.PC_WIDTH(32)) bus ();

  fetch_npc #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops and compares each word that decode accepts
  always @(negedge clk) begin
    if (rst_b && bus.if_valid && bus.id_ready && !bus.ex_redirect) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sbUnderflow", 64'(sbQueue.size()), 64'(1));
      end else begin
        sbEntry_t e;
        e = sbQueue.pop_front();
        checkOutput("sbInstr", 64'(bus.if_instr), 64'(e.instr));
        checkOutput("sbPc",    64'(bus.if_pc),    64'(e.pc));
        checkOutput("sbPred",  64'(bus.if_pred),  64'(e.pred));
      end
    end
  end

  // One full fetch starting in REQ: grant, then response, then check next PC
  task automatic applyStimulus(input logic [31:0] fetchPc,
                               input logic [31:0] word,
                               input logic [31:0] retAddr,
                               input logic [31:0] expNext,
                               input logic expJal, input logic expJr,
                               input logic expPred, input logic expHold);
    sbEntry_t e;
    checkOutput("reqHigh", 64'(bus.imem_req), 64'(1));
    checkOutput("reqAddr", 64'(bus.imem_addr), 64'(fetchPc));
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    #1;
    checkOutput("waitReqLow", 64'(bus.imem_req), 64'(0));
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word;
    bus.ret_addr    = retAddr;
    #1;
    checkOutput("jal", 64'(bus.i_jal), 64'(expJal));
    checkOutput("jr", 64'(bus.i_jr), 64'(expJr));
    checkOutput("pcplus4", 64'(bus.pcplus4), 64'(fetchPc + 32'd4));
    e.instr = word;
    e.pc    = fetchPc;
    e.pred  = expPred;
    sbQueue.push_back(e);
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    if (expHold) begin
      checkOutput("holdReqLow", 64'(bus.imem_req), 64'(0));
    end else begin
      checkOutput("nextAddr", 64'(bus.imem_addr), 64'(expNext));
      checkOutput("reqResume", 64'(bus.imem_req), 64'(1));
    end
  endtask

  // Redirect issued while sitting in REQ without a grant
  task automatic redirectInReq(input logic [31:0] target);
    bus.ex_redirect = 1'b1;
    bus.ex_target   = target;
    tick();
    bus.ex_redirect = 1'b0;
    #1;
    checkOutput("redirAddr", 64'(bus.imem_addr), 64'(target));
    checkOutput("redirReq", 64'(bus.imem_req), 64'(1));
  endtask

  task automatic waitForReq(input int budget);
    int n;
    n = 0;
    while (!bus.imem_req && n < budget) begin
      tick();
      n++;
    end
    checkOutput("reqWithinBudget", 64'(bus.imem_req), 64'(1));
  endtask

  // Main directed sequence
  initial begin
    checkCount      = 0;
    failCount       = 0;
    rst_b           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.ex_redirect = 1'b0;
    bus.ex_target   = 32'h0;
    bus.ret_addr    = 32'h0;
    bus.id_ready    = 1'b1;

    repeat (2) tick();
    checkOutput("rstReq",     64'(bus.imem_req), 64'(0));
    checkOutput("rstAddr",    64'(bus.imem_addr), 64'(0));
    checkOutput("rstIfValid", 64'(bus.if_valid), 64'(0));
    checkOutput("rstIfPred",  64'(bus.if_pred), 64'(0));
    checkOutput("rstIfInstr", 64'(bus.if_instr), 64'(0));
    checkOutput("rstIfPc",    64'(bus.if_pc), 64'(0));
    checkOutput("rstJal",     64'(bus.i_jal), 64'(0));
    checkOutput("rstJr",      64'(bus.i_jr), 64'(0));

    rst_b = 1'b1;
    waitForReq(4);
    applyStimulus(32'h0, 32'h0000_0000, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);

    tick();
    redirectInReq(32'h100);
    applyStimulus(32'h100, 32'h0C00_0040, 32'h0, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);

    tick();
    redirectInReq(32'h200);
    applyStimulus(32'h200, 32'h03E0_0008, 32'h104, 32'h104, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h104, 32'h0000_0008, 32'h0, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h108, 32'h0800_0010, 32'h0, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b0);

    tick();
    bus.id_ready = 1'b0;
    applyStimulus(32'h10C, 32'h2108_0001, 32'h0, 32'h110, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h110, 32'h03E0_0009, 32'h0, 32'h114, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("holdStillNoReq", 64'(bus.imem_req), 64'(0));
    checkOutput("holdIfStable", 64'(bus.if_instr), 64'(32'h2108_0001));
    bus.id_ready = 1'b1;
    tick();
    checkOutput("skidInstr", 64'(bus.if_instr), 64'(32'h03E0_0009));
    checkOutput("skidPc", 64'(bus.if_pc), 64'(32'h110));
    checkOutput("skidReq", 64'(bus.imem_req), 64'(1));
    checkOutput("skidAddr", 64'(bus.imem_addr), 64'(32'h114));

    tick();
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h400;
    #1;
    checkOutput("dropWaitReq", 64'(bus.imem_req), 64'(0));
    tick();
    bus.ex_redirect = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0C00_0040;
    #1;
    checkOutput("dropNoJal", 64'(bus.i_jal), 64'(0));
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checkOutput("dropAddr", 64'(bus.imem_addr), 64'(32'h400));
    checkOutput("dropReq", 64'(bus.imem_req), 64'(1));
    checkOutput("dropIfValid", 64'(bus.if_valid), 64'(0));

    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h03E0_0008;
    bus.ret_addr    = 32'h104;
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h600;
    #1;
    checkOutput("coRedirNoJr", 64'(bus.i_jr), 64'(0));
    tick();
    bus.imem_rvalid = 1'b0;
    bus.ex_redirect = 1'b0;
    #1;
    checkOutput("coRedirAddr", 64'(bus.imem_addr), 64'(32'h600));
    checkOutput("coRedirIfValid", 64'(bus.if_valid), 64'(0));
    applyStimulus(32'h600, 32'h0000_0000, 32'h0, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0);

    tick();
    bus.imem_gnt    = 1'b1;
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h800;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.ex_redirect = 1'b0;
    #1;
    checkOutput("gntRedirWait", 64'(bus.imem_req), 64'(0));
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0C00_0040;
    #1;
    checkOutput("gntRedirNoJal", 64'(bus.i_jal), 64'(0));
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checkOutput("gntRedirAddr", 64'(bus.imem_addr), 64'(32'h800));
    checkOutput("gntRedirIfValid", 64'(bus.if_valid), 64'(0));

    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    rst_b        = 1'b0;
    #1;
    checkOutput("midRstReq", 64'(bus.imem_req), 64'(0));
    checkOutput("midRstAddr", 64'(bus.imem_addr), 64'(0));
    tick();
    rst_b           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0C00_0040;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    checkOutput("lateRvalidReq", 64'(bus.imem_req), 64'(1));
    checkOutput("lateRvalidAddr", 64'(bus.imem_addr), 64'(0));
    checkOutput("lateRvalidIfValid", 64'(bus.if_valid), 64'(0));

    repeat (3) tick();
    checkOutput("sbDrained", 64'(sbQueue.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
